// File: rtl/fetch_stage_skid_reg.sv
// Fetch-stage pipeline register with a 2-entry skid buffer, valid/ready handshake and synchronous flush.
// Latency 1 cycle in_fire->out_valid; in_ready depends only on registered state, so a late stall never reaches upstream combinationally.
module fetch_stage_skid_reg #(
    parameter int unsigned           PC_W   = 32,
    parameter int unsigned           DATA_W = 32,
    parameter logic [PC_W-1:0]       PC_RST = 32'h1c000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   in_pc_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q = EMPTY;
    state_t              state_d;
    logic [PC_W-1:0]     head_pc_q = PC_RST;
    logic [PC_W-1:0]     head_pc_d;
    logic [DATA_W-1:0]   head_data_q = '0;
    logic [DATA_W-1:0]   head_data_d;
    logic [PC_W-1:0]     skid_pc_q = '0;
    logic [PC_W-1:0]     skid_pc_d;
    logic [DATA_W-1:0]   skid_data_q = '0;
    logic [DATA_W-1:0]   skid_data_d;

    logic in_fire;
    logic out_fire;

    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = (state_q != FULL);
    assign occupancy_o = state_q;
    assign out_pc_o    = head_pc_q;
    assign out_data_o  = head_data_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        head_pc_d   = head_pc_q;
        head_data_d = head_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;

        if (flush_i) begin
            state_d     = EMPTY;
            head_pc_d   = PC_RST;
            head_data_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        head_pc_d   = in_pc_i;
                        head_data_d = in_data_i;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_pc_d   = in_pc_i;
                        head_data_d = in_data_i;
                    end else if (in_fire) begin
                        skid_pc_d   = in_pc_i;
                        skid_data_d = in_data_i;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        head_pc_d   = skid_pc_q;
                        head_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Skid contents are don't-care after reset; only the state (its valid flag) is cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            head_pc_q   <= PC_RST;
            head_data_q <= '0;
        end else begin
            state_q     <= state_d;
            head_pc_q   <= head_pc_d;
            head_data_q <= head_data_d;
        end
        skid_pc_q   <= skid_pc_d;
        skid_data_q <= skid_data_d;
    end

endmodule

// File: tb/tb_fetch_stage_skid_reg.sv
// Bench for fetch_stage_skid_reg: directed scenarios plus random traffic against a FIFO-queue reference model.
module tb_fetch_stage_skid_reg;

    localparam logic [31:0] PC_RST = 32'h1c000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of held {pc,data}; shown_* is what the head should display.
    logic [63:0] m_q[$];
    logic [31:0] shown_pc   = PC_RST;
    logic [31:0] shown_data = '0;

    fetch_stage_skid_reg #(.PC_W(32), .DATA_W(32), .PC_RST(PC_RST)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_pc_i     (in_pc),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_pc_o    (out_pc),
        .out_data_o  (out_data),
        .occupancy_o (occupancy)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic cycle();
        bit do_pop, do_push;
        @(posedge clk);
        if (rst || flush) begin
            m_q.delete();
            shown_pc   = PC_RST;
            shown_data = '0;
        end else begin
            do_pop  = (m_q.size() > 0) && out_ready;
            do_push = in_valid && (m_q.size() < 2);
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back({in_pc, in_data});
            if (m_q.size() > 0) begin
                shown_pc   = m_q[0][63:32];
                shown_data = m_q[0][31:0];
            end
        end
        #1;
    endtask

    task automatic push_stall(input logic [31:0] pc);
        in_valid = 1'b1; in_pc = pc; in_data = $urandom; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'hdead_beef; out_ready = 1'b1;
        cycle(); cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        total++; if (out_pc !== 32'h1c000000) begin bad++; $display("FAIL reset_out_pc got=%h exp=1c000000", out_pc); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h1c000000 + 32'(4 * i);
            in_valid = 1'b1; in_pc = pc; in_data = $urandom;
            cycle();
            total++; if (out_valid !== 1'b1 || occupancy !== 2'd1 || out_pc !== pc || out_data !== shown_data) begin
                bad++; $display("FAIL stream_%0d got v=%0b occ=%0d pc=%h d=%h exp v=1 occ=1 pc=%h d=%h",
                                i, out_valid, occupancy, out_pc, out_data, pc, shown_data);
            end
        end
        in_valid = 1'b0;
        cycle();
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'h1c000008) begin
            bad++; $display("FAIL stream_drain got v=%0b occ=%0d pc=%h exp v=0 occ=0 pc=1c000008", out_valid, occupancy, out_pc);
        end
    endtask

    task automatic test_skid();
        push_stall(32'h100);
        total++; if (occupancy !== 2'd1 || out_pc !== 32'h100) begin bad++; $display("FAIL skid_a got occ=%0d pc=%h exp occ=1 pc=100", occupancy, out_pc); end
        push_stall(32'h104);
        total++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h100) begin
            bad++; $display("FAIL skid_full got occ=%0d rdy=%0b pc=%h exp occ=2 rdy=0 pc=100", occupancy, in_ready, out_pc);
        end
        in_valid = 1'b1; in_pc = 32'h108; in_data = 32'hc0de_0108;
        cycle();
        total++; if (occupancy !== 2'd2 || out_pc !== 32'h100) begin bad++; $display("FAIL skid_c_blocked got occ=%0d pc=%h exp occ=2 pc=100", occupancy, out_pc); end
        out_ready = 1'b1;
        cycle();
        total++; if (occupancy !== 2'd1 || out_pc !== 32'h104 || out_data !== shown_data) begin
            bad++; $display("FAIL skid_b got occ=%0d pc=%h d=%h exp occ=1 pc=104 d=%h", occupancy, out_pc, out_data, shown_data);
        end
        cycle();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd1 || out_pc !== 32'h108 || out_data !== 32'hc0de_0108) begin
            bad++; $display("FAIL skid_c got occ=%0d pc=%h d=%h exp occ=1 pc=108 d=c0de0108", occupancy, out_pc, out_data);
        end
        cycle();
        total++; if (out_valid !== 1'b0 || out_pc !== 32'h108 || out_data !== 32'hc0de_0108) begin
            bad++; $display("FAIL skid_hold got v=%0b pc=%h d=%h exp v=0 pc=108 d=c0de0108", out_valid, out_pc, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        push_stall(32'h1a0);
        push_stall(32'h1a4);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200; in_data = 32'h1234_5678;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== PC_RST || out_data !== 32'h0) begin
            bad++; $display("FAIL flush got occ=%0d v=%0b rdy=%0b pc=%h d=%h exp occ=0 v=0 rdy=1 pc=%h d=0",
                            occupancy, out_valid, in_ready, out_pc, out_data, PC_RST);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (out_valid !== 1'b0 || out_pc === 32'h200) begin
                bad++; $display("FAIL flush_leak_%0d got v=%0b pc=%h exp v=0", i, out_valid, out_pc);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        push_stall(32'h10);
        in_valid = 1'b1; in_pc = 32'h14; in_data = 32'h0000_0014; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        total++; if (out_pc !== 32'h14 || occupancy !== 2'd1 || out_data !== 32'h14) begin
            bad++; $display("FAIL simul got pc=%h occ=%0d d=%h exp pc=14 occ=1 d=14", out_pc, occupancy, out_data);
        end
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_stall(32'h300);
        push_stall(32'h304);
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h308; out_ready = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== PC_RST || out_data !== 32'h0) begin
            bad++; $display("FAIL reset_mid got occ=%0d v=%0b rdy=%0b pc=%h d=%h exp occ=0 v=0 rdy=1 pc=%h d=0",
                            occupancy, out_valid, in_ready, out_pc, out_data, PC_RST);
        end
        in_valid = 1'b1; in_pc = 32'h400; in_data = 32'h4;
        cycle();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            bad++; $display("FAIL reset_mid_first got v=%0b pc=%h exp v=1 pc=400", out_valid, out_pc);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            in_pc     = $urandom;
            in_data   = $urandom;
            cycle();
            total++;
            if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) ||
                occupancy !== 2'(m_q.size()) || out_pc !== shown_pc || out_data !== shown_data) begin
                bad++; errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d got v=%0b rdy=%0b occ=%0d pc=%h d=%h exp v=%0b rdy=%0b occ=%0d pc=%h d=%h",
                             i, out_valid, in_ready, occupancy, out_pc, out_data,
                             m_q.size() > 0, m_q.size() < 2, m_q.size(), shown_pc, shown_data);
            end
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
